sseg_scan: RTL

- Time-multiplexing controller for a bank of common-cathode 7-segment digits that share one `sseg` hex decoder.
- Each cycle it drives the decoder's 4-bit code and output-enable, plus a one-hot digit enable.
- Display value is loaded through a valid/ready handshake and applied only at frame boundaries, so frames never tear.
- Also provides PWM brightness, anti-ghosting dead time and optional leading-zero blanking.

---
 rtl/sseg_scan.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sseg_scan.sv
// Time-multiplexed 7-segment scan controller: one-hot digit enable, PWM brightness
// with slot-0 dead time, leading-zero blanking and frame-aligned display loads.
module sseg_scan #(
  parameter int DIGITS   = 4,
  parameter int SLOT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [3:0]            bright,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  load_blank_lz,
  output logic [3:0]            digit_code,
  output logic                  seg_oe,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_tick
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] DIG_ONE = DIGITS'(1);

  typedef enum logic {ST_OFF = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic [CW-1:0]       cyc_r, cyc_next_s;
  logic [3:0]          slot_r, slot_next_s;
  logic [DW-1:0]       dig_r, dig_next_s;
  logic [4*DIGITS-1:0] disp_r, shadow_r, disp_next_s;
  logic                blank_r, sblank_r, blank_next_s;
  logic                pend_r, pend_next_s;
  logic [3:0]          bright_r;
  logic                win_start_s, boundary_s, apply_s, xfer_s;
  logic                zero_above_s, oe_next_s;
  logic [DIGITS-1:0]   lz_mask_s;
  logic [3:0]          nib_s;
  logic [DIGITS-1:0]   dig_en_r;
  logic [3:0]          digit_code_r;
  logic                seg_oe_r, frame_tick_r, load_ready_r;

  assign dig_en     = dig_en_r;
  assign digit_code = digit_code_r;
  assign seg_oe     = seg_oe_r;
  assign frame_tick = frame_tick_r;
  assign load_ready = load_ready_r;

  // Scan state follows enable; counters restart at zero whenever the scan stops.
  always_comb begin
    state_next_s = state_r;
    cyc_next_s   = '0;
    slot_next_s  = 4'd0;
    dig_next_s   = '0;
    case (state_r)
      ST_OFF:  state_next_s = enable ? ST_SCAN : ST_OFF;
      ST_SCAN: state_next_s = enable ? ST_SCAN : ST_OFF;
      default: state_next_s = ST_OFF;
    endcase
    if (enable) begin
      cyc_next_s  = cyc_r + CW'(1);
      slot_next_s = slot_r;
      dig_next_s  = dig_r;
      if (cyc_r == CW'(SLOT_CYC - 1)) begin
        cyc_next_s = '0;
        if (slot_r == 4'd15) begin
          slot_next_s = 4'd0;
          if (dig_r == DW'(DIGITS - 1)) begin
            dig_next_s = '0;
          end else begin
            dig_next_s = dig_r + DW'(1);
          end
        end else begin
          slot_next_s = slot_r + 4'd1;
        end
      end else begin
        cyc_next_s = cyc_r + CW'(1);
      end
    end else begin
      cyc_next_s = '0;
    end
  end

  // Load handshake, frame-aligned display update and per-digit output terms.
  always_comb begin
    win_start_s  = (slot_r == 4'd0) && (cyc_r == '0);
    boundary_s   = enable && win_start_s && (dig_r == '0);
    apply_s      = pend_r && ((state_r == ST_OFF) || boundary_s);
    xfer_s       = load_valid && load_ready_r;
    disp_next_s  = disp_r;
    blank_next_s = blank_r;
    pend_next_s  = pend_r;
    if (apply_s) begin
      disp_next_s  = shadow_r;
      blank_next_s = sblank_r;
      pend_next_s  = 1'b0;
    end else if (xfer_s) begin
      pend_next_s  = 1'b1;
    end else begin
      pend_next_s  = pend_r;
    end
    // A digit is blank only when it and every more significant nibble are zero.
    zero_above_s = 1'b1;
    lz_mask_s    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above_s = zero_above_s & (disp_next_s[4*i +: 4] == 4'd0);
      lz_mask_s[i] = blank_next_s & zero_above_s;
    end
    nib_s     = disp_next_s[{dig_r, 2'b00} +: 4];
    oe_next_s = (slot_r != 4'd0) && (slot_r <= bright_r) && !lz_mask_s[dig_r];
  end

  // State, counters, display/shadow registers and handshake ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_OFF;
      cyc_r        <= '0;
      slot_r       <= 4'd0;
      dig_r        <= '0;
      disp_r       <= '0;
      shadow_r     <= '0;
      blank_r      <= 1'b0;
      sblank_r     <= 1'b0;
      pend_r       <= 1'b0;
      bright_r     <= 4'd0;
      load_ready_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      cyc_r        <= cyc_next_s;
      slot_r       <= slot_next_s;
      dig_r        <= dig_next_s;
      disp_r       <= disp_next_s;
      blank_r      <= blank_next_s;
      pend_r       <= pend_next_s;
      load_ready_r <= ~pend_next_s;
      if (xfer_s) begin
        shadow_r <= load_data;
        sblank_r <= load_blank_lz;
      end
      if (enable && win_start_s) begin
        bright_r <= bright;
      end
    end
  end

  // Registered display outputs; dark whenever the scan is not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en_r     <= '0;
      digit_code_r <= 4'd0;
      seg_oe_r     <= 1'b0;
      frame_tick_r <= 1'b0;
    end else if (enable) begin
      dig_en_r     <= DIG_ONE << dig_r;
      digit_code_r <= nib_s;
      seg_oe_r     <= oe_next_s;
      frame_tick_r <= boundary_s;
    end else begin
      dig_en_r     <= '0;
      digit_code_r <= 4'd0;
      seg_oe_r     <= 1'b0;
      frame_tick_r <= 1'b0;
    end
  end

endmodule
